// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        DONE,
        ERR
    } lsu_state_t;

    // True when funct3 is not a valid load/store encoding or the byte offset
    // does not match the access size.
    function automatic logic req_is_illegal(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic bad_funct3;
        logic misaligned;
        if (is_store) begin
            bad_funct3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            bad_funct3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                           funct3 == F3_BU || funct3 == F3_HU);
        end
        case (funct3[1:0])
            F3_H[1:0]: misaligned = addr_lo[0];
            F3_W[1:0]: misaligned = (addr_lo != 2'b00);
            default:   misaligned = 1'b0;
        endcase
        return bad_funct3 || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extraction with sign/zero
// extension, and store merge of the addressed lane(s) into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [1:0]  size;
    logic        is_unsigned;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] store_lanes;
    logic [3:0]  lane_sel;

    assign size        = funct3[1:0];
    assign is_unsigned = funct3[2];
    assign load_byte   = mem_word[{addr_lo, 3'b000} +: 8];
    assign load_half   = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    // Store data is replicated across every lane so the merge below only has
    // to pick, per byte, between the new lane and the old memory byte.
    always_comb begin
        load_value  = mem_word;
        store_lanes = store_data;
        case (size)
            F3_B[1:0]: begin
                load_value  = {{24{~is_unsigned & load_byte[7]}}, load_byte};
                store_lanes = {4{store_data[7:0]}};
            end
            F3_H[1:0]: begin
                load_value  = {{16{~is_unsigned & load_half[15]}}, load_half};
                store_lanes = {2{store_data[15:0]}};
            end
            default: begin
                load_value  = mem_word;
                store_lanes = store_data;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = (size == F3_W[1:0]) ||
                                  ((size == F3_H[1:0]) && (addr_lo[1] == LANE[1])) ||
                                  ((size == F3_B[1:0]) && (addr_lo == LANE));
            assign merged_word[8*gi +: 8] = lane_sel[gi] ? store_lanes[8*gi +: 8]
                                                         : mem_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_mem_controller.sv
// Load/store initiator between the MEM stage and a word-addressed data memory
// with 1-cycle read latency; sub-word stores use read-modify-write.
module lsu_mem_controller
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int MEMORY_DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              byte_addr,
    input  logic [DATA_WIDTH-1:0]    store_data,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    load_data,
    output logic                     addr_err,
    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_t              state_reg;
    lsu_state_t              state_next;
    logic                    is_store_reg;
    logic [2:0]              funct3_reg;
    logic [31:0]             addr_reg;
    logic [DATA_WIDTH-1:0]   store_data_reg;
    logic [DATA_WIDTH-1:0]   load_data_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;

    logic                    accept;
    logic                    out_of_range;
    logic                    req_err;
    logic [DATA_WIDTH-1:0]   load_value;
    logic [DATA_WIDTH-1:0]   merged_word;

    assign accept       = (state_reg == IDLE) && start;
    assign out_of_range = ({2'b00, byte_addr[31:2]} >= 32'(MEMORY_DEPTH));
    assign req_err      = req_is_illegal(is_store, funct3, byte_addr[1:0]) || out_of_range;

    lsu_align u_align (
        .funct3      (funct3_reg),
        .addr_lo     (addr_reg[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (store_data_reg),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Memory enables and handshake outputs decode purely from state so that
    // an asynchronous reset drops them immediately.
    always_comb begin
        state_next   = state_reg;
        busy         = 1'b1;
        done         = 1'b0;
        addr_err     = 1'b0;
        mem_read_En  = 1'b0;
        mem_write_En = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (req_err) begin
                        state_next = ERR;
                    end else if (is_store && (funct3 == F3_W)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                mem_read_En = 1'b1;
                state_next  = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = is_store_reg ? WR : DONE;
            end
            WR: begin
                mem_write_En = 1'b1;
                state_next   = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                addr_err   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word-store data is captured at accept; sub-word stores overwrite it with
    // the merged word once the old contents arrive in RD_WAIT.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            is_store_reg   <= 1'b0;
            funct3_reg     <= 3'b000;
            addr_reg       <= '0;
            store_data_reg <= '0;
            load_data_reg  <= '0;
            wdata_reg      <= '0;
        end else begin
            if (accept) begin
                is_store_reg   <= is_store;
                funct3_reg     <= funct3;
                addr_reg       <= byte_addr;
                store_data_reg <= store_data;
                wdata_reg      <= store_data;
            end
            if (state_reg == RD_WAIT) begin
                if (is_store_reg) begin
                    wdata_reg <= merged_word;
                end else begin
                    load_data_reg <= load_value;
                end
            end
        end
    end

    assign load_data   = load_data_reg;
    assign mem_address = addr_reg[ADDRESS_WIDTH+1:2];
    assign mem_wdata   = wdata_reg;

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Self-checking bench for lsu_mem_controller: directed and random requests
// against an arithmetic reference model of memory and the load/store rules.
module tb_lsu_mem_controller;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] byte_addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        addr_err;
    logic        mem_read_En;
    logic        mem_write_En;
    logic [29:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    logic [31:0] dmem    [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] exp_load_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: registered read, write on the clock edge, plus a preload port.
    always @(posedge clk) begin
        if (mem_read_En) mem_rdata <= dmem[mem_address[11:0]];
        if (mem_write_En && (mem_address < 30'(DEPTH))) dmem[mem_address[11:0]] <= mem_wdata;
        if (pl_en) dmem[pl_addr] <= pl_data;
    end

    lsu_mem_controller #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (30),
        .MEMORY_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .start        (start),
        .is_store     (is_store),
        .funct3       (funct3),
        .byte_addr    (byte_addr),
        .store_data   (store_data),
        .busy         (busy),
        .done         (done),
        .load_data    (load_data),
        .addr_err     (addr_err),
        .mem_read_En  (mem_read_En),
        .mem_write_En (mem_write_En),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    task automatic preload(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = idx[11:0]; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Issues one request, watches the bus until done, and checks everything
    // against the reference model. Leaves the bench at the negedge of done.
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input string tag,
                           output logic [31:0] obs_load, output logic [31:0] obs_wdata,
                           output int obs_lat);
        int nbytes, off, widx, exp_lat, exp_reads, exp_writes;
        int reads, writes, lat, bad_addr, both, not_busy;
        bit legal, aligned, inrange, exp_err;
        logic [31:0] word, new_word, exp_ld;
        logic [31:0] wr_data;
        logic [29:0] wr_addr;
        logic got_err;
        longint raw;
        reads = 0; writes = 0; lat = 0; bad_addr = 0; both = 0; not_busy = 0;
        wr_data = '0; wr_addr = '0; got_err = 1'b0;

        nbytes   = 1 << (f3 % 4);
        off      = int'(addr % 4);
        widx     = int'(addr / 4);
        legal    = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        aligned  = (off % nbytes) == 0;
        inrange  = widx < DEPTH;
        exp_err  = !(legal && aligned && inrange);
        word     = inrange ? ref_mem[widx] : 32'h0;
        new_word = word;
        exp_ld   = exp_load_data;
        if (exp_err) begin
            exp_lat = 1; exp_reads = 0; exp_writes = 0;
        end else if (!st) begin
            exp_lat = 3; exp_reads = 1; exp_writes = 0;
            raw = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
            if (f3 < 4 && raw >= longint'(64'd1 << (8 * nbytes - 1)))
                raw = raw - longint'(64'd1 << (8 * nbytes));
            exp_ld = raw[31:0];
        end else begin
            exp_lat    = (f3 == 2) ? 2 : 4;
            exp_reads  = (f3 == 2) ? 0 : 1;
            exp_writes = 1;
            for (int k = 0; k < nbytes; k++) new_word[8*(off+k) +: 8] = sd[8*k +: 8];
        end

        @(posedge clk); #1;
        start = 1'b1; is_store = st; funct3 = f3; byte_addr = addr; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_read_En) begin
                reads++;
                if (mem_address !== widx[29:0]) bad_addr++;
            end
            if (mem_write_En) begin
                writes++; wr_data = mem_wdata; wr_addr = mem_address;
            end
            if (mem_read_En && mem_write_En) both++;
            if (busy !== 1'b1) not_busy++;
            if (done === 1'b1) begin
                lat = k; got_err = addr_err; last_done_cyc = cyc;
                break;
            end
        end

        checks++; if (lat != exp_lat) begin failures++;
            $display("FAIL %s latency got=%0d exp=%0d (0 means timeout)", tag, lat, exp_lat); end
        checks++; if (got_err !== exp_err) begin failures++;
            $display("FAIL %s addr_err got=%0b exp=%0b", tag, got_err, exp_err); end
        checks++; if (reads != exp_reads || bad_addr != 0) begin failures++;
            $display("FAIL %s reads got=%0d exp=%0d bad_addr=%0d", tag, reads, exp_reads, bad_addr); end
        checks++; if (writes != exp_writes || both != 0) begin failures++;
            $display("FAIL %s writes got=%0d exp=%0d overlap=%0d", tag, writes, exp_writes, both); end
        checks++; if (not_busy != 0) begin failures++;
            $display("FAIL %s busy low cycles got=%0d exp=0", tag, not_busy); end
        checks++; if (load_data !== exp_ld) begin failures++;
            $display("FAIL %s load_data got=%h exp=%h", tag, load_data, exp_ld); end
        if (exp_writes == 1) begin
            checks++; if (wr_addr !== widx[29:0] || wr_data !== new_word) begin failures++;
                $display("FAIL %s write got=%h@%h exp=%h@%h", tag, wr_data, wr_addr, new_word, widx[29:0]); end
            checks++; if (dmem[widx] !== new_word) begin failures++;
                $display("FAIL %s memory word got=%h exp=%h", tag, dmem[widx], new_word); end
            ref_mem[widx] = new_word;
        end
        exp_load_data = exp_ld;
        $display("txn %s st=%0d f3=%0d addr=%h sd=%h lat=%0d err=%0b ld=%h",
                 tag, st, f3, addr, sd, lat, got_err, load_data);
        obs_load = load_data; obs_wdata = wr_data; obs_lat = lat;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, addr_err, mem_read_En, mem_write_En} !== 5'b0) begin failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, addr_err, mem_read_En, mem_write_En}); end
        checks++; if (load_data !== 32'h0) begin failures++;
            $display("FAIL reset_load_data got=%h exp=0", load_data); end
        checks++; if (mem_address !== 30'h0 || mem_wdata !== 32'h0) begin failures++;
            $display("FAIL reset_bus got=%h/%h exp=0/0", mem_address, mem_wdata); end
        rstN = 1'b1;
        exp_load_data = 32'h0;
        $display("txn reset released");
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        logic [31:0] ld, wd;
        int lat;
        preload(4, 32'h80FF7F01);
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3s[i], adrs[i], 32'h0, "load", ld, wd, lat);
            checks++; if (ld !== exps[i] || lat != 3) begin failures++;
                $display("FAIL load_plan%0d got=%h lat=%0d exp=%h lat=3", i, ld, lat, exps[i]); end
        end
    endtask

    task automatic test_store_byte();
        logic [31:0] ld, wd;
        int lat;
        run_req(1'b1, 3'b000, 32'h11, 32'h123456AB, "sb", ld, wd, lat);
        checks++; if (wd !== 32'h80FFAB01 || lat != 4) begin failures++;
            $display("FAIL sb_plan got=%h lat=%0d exp=80ffab01 lat=4", wd, lat); end
    endtask

    task automatic test_store_word();
        logic [31:0] ld, wd;
        int lat;
        run_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, "sw", ld, wd, lat);
        checks++; if (wd !== 32'hDEADBEEF || lat != 2) begin failures++;
            $display("FAIL sw_plan got=%h lat=%0d exp=deadbeef lat=2", wd, lat); end
    endtask

    task automatic test_errors();
        logic        sts  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3s  [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
        logic [31:0] adrs [4] = '{32'h13, 32'h22, 32'h10, 32'h4000};
        logic [31:0] ld, wd;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_req(sts[i], f3s[i], adrs[i], 32'hA5A5A5A5, "err", ld, wd, lat);
            checks++; if (lat != 1) begin failures++;
                $display("FAIL err_plan%0d latency got=%0d exp=1", i, lat); end
        end
        preload(DEPTH - 1, 32'hC001D00D);
        run_req(1'b0, 3'b010, 32'h3FFC, 32'h0, "last_word", ld, wd, lat);
        checks++; if (ld !== 32'hC001D00D) begin failures++;
            $display("FAIL last_word got=%h exp=c001d00d", ld); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ld, wd;
        int lat;
        preload(4, 32'h80FF7F01);
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; byte_addr = 32'h11; store_data = 32'h123456AB;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rstN = 1'b0;
        #1;
        checks++; if ({busy, done, addr_err, mem_read_En, mem_write_En} !== 5'b0) begin failures++;
            $display("FAIL abort_ctrl got=%b exp=00000", {busy, done, addr_err, mem_read_En, mem_write_En}); end
        checks++; if (load_data !== 32'h0 || mem_address !== 30'h0 || mem_wdata !== 32'h0) begin failures++;
            $display("FAIL abort_data got=%h/%h/%h exp=0/0/0", load_data, mem_address, mem_wdata); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dmem[4] !== ref_mem[4]) begin failures++;
            $display("FAIL abort_memory got=%h exp=%h", dmem[4], ref_mem[4]); end
        @(negedge clk);
        rstN = 1'b1;
        exp_load_data = 32'h0;
        $display("txn reset during RD_WAIT released");
        run_req(1'b1, 3'b000, 32'h11, 32'h123456AB, "sb_after_abort", ld, wd, lat);
        checks++; if (wd !== 32'h80FFAB01) begin failures++;
            $display("FAIL sb_after_abort got=%h exp=80ffab01", wd); end
    endtask

    task automatic test_ignored_start();
        int dones, addr_moves;
        dones = 0; addr_moves = 0;
        preload(4, 32'h13579BDF);
        preload(5, 32'h2468ACE0);
        preload(6, 32'h0F1E2D3C);
        @(posedge clk); #1;
        fork
            begin
                start = 1'b1; is_store = 1'b0; funct3 = 3'b010; byte_addr = 32'h10; store_data = 32'h0;
                @(posedge clk); #1;
                byte_addr = 32'h14;
                @(posedge clk); #1;
                start = 1'b0;
                @(posedge clk); #1;
                start = 1'b1; byte_addr = 32'h18;
                @(posedge clk); #1;
                start = 1'b0;
            end
            begin
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    if (done === 1'b1) dones++;
                    if (k >= 2 && k <= 4 && mem_address !== 30'd4) addr_moves++;
                end
            end
        join
        checks++; if (dones != 1) begin failures++;
            $display("FAIL ignored_start dones got=%0d exp=1", dones); end
        checks++; if (addr_moves != 0) begin failures++;
            $display("FAIL ignored_start address changes got=%0d exp=0", addr_moves); end
        checks++; if (load_data !== ref_mem[4]) begin failures++;
            $display("FAIL ignored_start load_data got=%h exp=%h", load_data, ref_mem[4]); end
        exp_load_data = ref_mem[4];
        $display("txn ignored start dones=%0d ld=%h", dones, load_data);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ld, wd;
        int lat, d1;
        run_req(1'b0, 3'b010, 32'h10, 32'h0, "b2b_first", ld, wd, lat);
        d1 = last_done_cyc;
        run_req(1'b0, 3'b010, 32'h14, 32'h0, "b2b_second", ld, wd, lat);
        checks++; if (last_done_cyc - d1 != 4) begin failures++;
            $display("FAIL back_to_back done spacing got=%0d exp=4", last_done_cyc - d1); end
    endtask

    task automatic test_random();
        logic [31:0] ld, wd, addr;
        logic [2:0]  f3;
        logic        st;
        int lat, r;
        for (int i = 0; i < 16; i++) preload(i, $urandom());
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                r = int'($urandom_range(0, st ? 2 : 4));
                f3 = (r > 2) ? 3'(r + 1) : 3'(r);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            r = int'($urandom_range(0, 9));
            if (r <= 7)      addr = 32'($urandom_range(0, 63));
            else if (r == 8) addr = 32'h3FFC + 32'($urandom_range(0, 3));
            else             addr = $urandom() | 32'h4000;
            run_req(st, f3, addr, $urandom(), "rand", ld, wd, lat);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        byte_addr = 32'h0; store_data = 32'h0;
        pl_en = 1'b0; pl_addr = 12'h0; pl_data = 32'h0;
        exp_load_data = 32'h0;
        test_reset();
        test_loads();
        test_store_byte();
        test_store_word();
        test_errors();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_controller.md
Name: lsu_mem_controller

Overview:
- Load/store initiator sitting between the RV32I core's MEM stage and the word-addressed data memory.
- Converts one byte-addressed core request (LB/LH/LW/LBU/LHU/SB/SH/SW) into data-memory read/write cycles.
- Memory has 1-cycle registered read latency and no byte enables, so SB/SH use read-modify-write.
- Performs load lane extraction, sign/zero extension and alignment checking.

Parameters:
DATA_WIDTH, 32, width of data words (fixed 32 for RV32; other values unsupported)
ADDRESS_WIDTH, 30, word-address width driven to data memory
MEMORY_DEPTH, 4096, words in data memory; byte addresses beyond 4*MEMORY_DEPTH-1 flag addr_err

Ports:
clk  input  1  system clock, all state on rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  request strobe, accepted only in IDLE
is_store  input  1  1 = store, 0 = load
funct3  input  3  RV32I funct3 of the load/store
byte_addr  input  32  byte address
store_data  input  DATA_WIDTH  store source register value
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
load_data  output  DATA_WIDTH  extended load result, valid from done, held until next load completes
addr_err  output  1  with done: misaligned, out-of-range or illegal funct3; request not executed
mem_read_En  output  1  to data memory read_En
mem_write_En  output  1  to data memory write_En
mem_address  output  ADDRESS_WIDTH  word address = latched byte_addr[ADDRESS_WIDTH+1:2]
mem_wdata  output  DATA_WIDTH  to data memory data_in
mem_rdata  input  DATA_WIDTH  from data memory data_out

Behaviour:
- Reset (async, rstN low): state IDLE. busy, done, addr_err, mem_read_En and mem_write_En are 0. load_data, mem_address and mem_wdata are 0. Memory enables drop immediately because they decode from state.
- IDLE + start: latch is_store, funct3, byte_addr, store_data, then check the request.
- Error cases:
  - illegal funct3: loads 011/110/111, stores other than 000/001/010
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
  - word address >= MEMORY_DEPTH
  - On any error: go to ERR. No memory access; load_data unchanged.
- Normal transitions from IDLE: SW -> WR; all loads and SB/SH -> RD.
- States:
  - RD: mem_read_En=1 -> RD_WAIT.
  - RD_WAIT: mem_rdata valid. Load: register extracted value into load_data -> DONE. SB/SH: register merged word -> WR.
  - WR: mem_write_En=1, mem_wdata = merged word (SW: store_data) -> DONE.
  - DONE: done=1 -> IDLE.
  - ERR: done=1, addr_err=1 -> IDLE.
- Only one of mem_read_En / mem_write_En is ever high. mem_address is stable from RD or WR through DONE.
- Latency (start-accept edge = cycle 0, done high in cycle N): loads N=3, SW N=2, SB/SH N=4, error N=1.
- Lanes are little-endian: byte k = bits[8k+7:8k], k = addr[1:0]; halfword at addr[1]*16.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH replace only the addressed lane(s); other bytes come from the word read in RD_WAIT.
- start while busy is ignored, not queued. start in the DONE cycle is also ignored; the core waits for IDLE.
- Back-to-back: start asserted in the cycle after done is accepted.
- Reset mid-operation aborts with no write unless WR's edge already occurred. An SB/SH aborted in RD/RD_WAIT leaves memory unchanged.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - typedef enum logic [2:0] lsu_state_t {IDLE, RD, RD_WAIT, WR, DONE, ERR}
- Sub-module lsu_align (combinational) provides load extract/extend and store merge, given funct3, addr[1:0], the word and store data. It is unit-testable exhaustively.

Test Plan:
- Memory word 4 = 0x80FF7F01. Issue LB 0x13, LBU 0x13, LH 0x12, LHU 0x10, LW 0x10. Required load_data: 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x00007F01, 0x80FF7F01, each with done 3 cycles after start.
- SB 0x11 with store_data 0x123456AB, word 4 = 0x80FF7F01. Required: one read then one write of 0x80FFAB01 to word 4; done at cycle 4; bytes 0, 2 and 3 unchanged.
- SW 0x20 with 0xDEADBEEF. Required: no mem_read_En; mem_write_En one cycle with address 8 and data 0xDEADBEEF; done at cycle 2.
- Error requests: SH 0x13, LW 0x22, funct3=011 load, byte_addr 0x4000 (word 4096). Required: done+addr_err at cycle 1, both memory enables 0 throughout, load_data unchanged.
- SB 0x11 with rstN pulled low during RD_WAIT. Required: all outputs 0 asynchronously, no write, word 4 unchanged; a new start after rstN release completes normally.
- start pulsed during RD of a prior LW is ignored: exactly one done, mem_address unchanged. Back-to-back LW 0x10 and LW 0x14 return correct data with done 4 cycles apart.
